// File: rtl/alarm_ui_ctrl_pkg.sv
// Shared types and sizing for the alarm clock UI sequencer.
package alarm_ui_ctrl_pkg;
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    SET_A_HR  = 3'd3,
    SET_A_MIN = 3'd4,
    RINGING   = 3'd5,
    SNOOZE    = 3'd6
  } ui_state_t;

  localparam int SNOOZE_SEC_DEF   = 300;
  localparam int RING_TIMEOUT_DEF = 60;
  localparam int MAX_SNOOZES_DEF  = 3;

  localparam int NUM_BTN = 4;
  localparam int B_MODE  = 0;
  localparam int B_ADV   = 1;
  localparam int B_SNZ   = 2;
  localparam int B_STOP  = 3;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SNZ_W  = cnt_w(SNOOZE_SEC_DEF + 1);
  localparam int RING_W = cnt_w(RING_TIMEOUT_DEF);
  localparam int SNZC_W = cnt_w(MAX_SNOOZES_DEF + 1);

  // Mode button walks the setting states in a ring back to RUN.
  function automatic ui_state_t next_set(input ui_state_t s);
    case (s)
      RUN:       return SET_T_HR;
      SET_T_HR:  return SET_T_MIN;
      SET_T_MIN: return SET_A_HR;
      SET_A_HR:  return SET_A_MIN;
      default:   return RUN;
    endcase
  endfunction
endpackage

// File: rtl/alarm_ui_ctrl_if.sv
// Board-side buttons/status in, datapath control strobes out.
interface alarm_ui_ctrl_if;
  logic tick_1hz;
  logic btn_mode;
  logic btn_adv;
  logic btn_snooze;
  logic btn_stop;
  logic alarm_en_sw;
  logic alarm_match;
  logic time_set;
  logic alarm_set;
  logic sethrs1min0;
  logic adv_pulse;
  logic run;
  logic activatealarm;
  logic alarmreset;
  logic buzzer;
  logic [2:0] state_o;
  logic [alarm_ui_ctrl_pkg::SNZ_W-1:0] snooze_left;

  modport master (
    output tick_1hz, btn_mode, btn_adv, btn_snooze, btn_stop, alarm_en_sw, alarm_match,
    input  time_set, alarm_set, sethrs1min0, adv_pulse, run, activatealarm, alarmreset,
           buzzer, state_o, snooze_left
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_adv, btn_snooze, btn_stop, alarm_en_sw, alarm_match,
    output time_set, alarm_set, sethrs1min0, adv_pulse, run, activatealarm, alarmreset,
           buzzer, state_o, snooze_left
  );
endinterface

// File: rtl/alarm_ui_ctrl_btn_edge.sv
// Registers a synchronised button level and flags its rising edge.
module alarm_ui_ctrl_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign press = btn & ~btn_q;
endmodule

// File: rtl/alarm_ui_ctrl.sv
// Alarm clock UI sequencer: button decode, setting modes and ring/snooze policy.
module alarm_ui_ctrl
  import alarm_ui_ctrl_pkg::*;
#(
  parameter int SNOOZE_SEC   = SNOOZE_SEC_DEF,
  parameter int RING_TIMEOUT = RING_TIMEOUT_DEF,
  parameter int MAX_SNOOZES  = MAX_SNOOZES_DEF
) (
  input logic           clk,
  input logic           reset,
  alarm_ui_ctrl_if.slave bus
);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);
  localparam logic [SNZC_W-1:0] SNZ_MAX   = SNZC_W'(MAX_SNOOZES);

  logic [NUM_BTN-1:0] btns, press;
  ui_state_t          state_q, state_d;
  logic [RING_W-1:0]  ring_q, ring_d;
  logic [SNZ_W-1:0]   snzl_q, snzl_d;
  logic [SNZC_W-1:0]  snzc_q, snzc_d;
  logic               match_q, match_rise, stop_req, timeout;
  logic               adv_d, arst_d, time_set_d;

  assign btns = {bus.btn_stop, bus.btn_snooze, bus.btn_adv, bus.btn_mode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    alarm_ui_ctrl_btn_edge u_edge (
      .clk   (clk),
      .reset (reset),
      .btn   (btns[i]),
      .press (press[i])
    );
  end

  assign match_rise = bus.alarm_match & ~match_q;
  assign stop_req   = press[B_STOP] | ~bus.alarm_en_sw;
  assign timeout    = (state_q == RINGING) && bus.tick_1hz && (ring_q == RING_LAST);
  assign time_set_d = (state_d == SET_T_HR) || (state_d == SET_T_MIN);

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snzl_d  = snzl_q;
    snzc_d  = snzc_q;
    adv_d   = 1'b0;
    arst_d  = 1'b0;
    case (state_q)
      RUN: begin
        // An alarm edge outranks a simultaneous mode press.
        if (bus.alarm_en_sw && match_rise) begin
          state_d = RINGING;
          ring_d  = '0;
          snzc_d  = '0;
        end else if (press[B_MODE]) begin
          state_d = next_set(state_q);
        end
      end
      SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN: begin
        if (press[B_MODE]) state_d = next_set(state_q);
        else               adv_d   = press[B_ADV];
      end
      RINGING, SNOOZE: begin
        if (stop_req || timeout) begin
          state_d = RUN;
          arst_d  = 1'b1;
          ring_d  = '0;
          snzl_d  = '0;
          snzc_d  = '0;
        end else if (state_q == SNOOZE) begin
          if (snzl_q == '0 || (bus.tick_1hz && snzl_q == SNZ_W'(1))) begin
            state_d = RINGING;
            ring_d  = '0;
            snzl_d  = '0;
          end else if (bus.tick_1hz) begin
            snzl_d = snzl_q - 1'b1;
          end
        end else if (press[B_SNZ] && snzc_q < SNZ_MAX) begin
          state_d = SNOOZE;
          snzl_d  = SNZ_LOAD;
          snzc_d  = snzc_q + 1'b1;
        end else if (bus.tick_1hz && ring_q != RING_LAST) begin
          ring_d = ring_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are decoded from the next state so every one leaves a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RUN;
      bus.time_set      <= 1'b0;
      bus.alarm_set     <= 1'b0;
      bus.sethrs1min0   <= 1'b0;
      bus.adv_pulse     <= 1'b0;
      bus.run           <= 1'b1;
      bus.activatealarm <= 1'b0;
      bus.alarmreset    <= 1'b0;
      bus.buzzer        <= 1'b0;
      bus.state_o       <= RUN;
    end else begin
      state_q           <= state_d;
      bus.time_set      <= time_set_d;
      bus.alarm_set     <= (state_d == SET_A_HR) || (state_d == SET_A_MIN);
      bus.sethrs1min0   <= (state_d == SET_T_HR) || (state_d == SET_A_HR);
      bus.adv_pulse     <= adv_d;
      bus.run           <= ~time_set_d;
      bus.activatealarm <= bus.alarm_en_sw;
      bus.alarmreset    <= arst_d;
      bus.buzzer        <= (state_d == RINGING);
      bus.state_o       <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q  <= '0;
      snzl_q  <= '0;
      snzc_q  <= '0;
      match_q <= 1'b0;
    end else begin
      ring_q  <= ring_d;
      snzl_q  <= snzl_d;
      snzc_q  <= snzc_d;
      match_q <= bus.alarm_match;
    end
  end

  assign bus.snooze_left = snzl_q;
endmodule

// File: tb/tb_alarm_ui_ctrl.sv
// Bench for alarm_ui_ctrl: directed scenarios plus random traffic against a reference model.
module tb_alarm_ui_ctrl;
  localparam int SS   = 5;
  localparam int RT   = 60;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alarm_ui_ctrl_if bus ();

  alarm_ui_ctrl #(.SNOOZE_SEC(SS), .RING_TIMEOUT(RT), .MAX_SNOOZES(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: ui position 0..4, alarm phase 0 idle / 1 ringing / 2 snoozing.
  int m_set = 0, m_alm = 0, m_ring = 0, m_left = 0, m_used = 0;
  bit e_adv = 0, e_arst = 0, e_act = 0;
  bit [3:0] prev_btn = '0;
  bit prev_match = 0;

  always @(posedge clk) begin
    bit [3:0] lvl, pr;
    bit rise;
    lvl = {bus.btn_stop, bus.btn_snooze, bus.btn_adv, bus.btn_mode};
    pr = lvl & ~prev_btn;
    rise = bus.alarm_match & ~prev_match;
    e_adv = 0;
    e_arst = 0;
    if (reset) begin
      m_set = 0; m_alm = 0; m_ring = 0; m_left = 0; m_used = 0;
      e_act = 0; prev_btn = '0; prev_match = 0;
    end else begin
      if (m_alm != 0) begin
        if (pr[3] || !bus.alarm_en_sw || (m_alm == 1 && bus.tick_1hz && m_ring == RT - 1)) begin
          m_alm = 0; m_ring = 0; m_left = 0; m_used = 0; e_arst = 1;
        end else if (m_alm == 2) begin
          if (m_left == 0 || (bus.tick_1hz && m_left == 1)) begin
            m_alm = 1; m_ring = 0; m_left = 0;
          end else if (bus.tick_1hz) m_left--;
        end else if (pr[2] && m_used < MAXS) begin
          m_alm = 2; m_left = SS; m_used++;
        end else if (bus.tick_1hz) m_ring = (m_ring + 1 > RT - 1) ? RT - 1 : m_ring + 1;
      end else if (m_set == 0 && bus.alarm_en_sw && rise) begin
        m_alm = 1; m_ring = 0; m_used = 0;
      end else if (pr[0]) m_set = (m_set + 1) % 5;
      else if (pr[1] && m_set != 0) e_adv = 1;
      e_act = bus.alarm_en_sw;
      prev_btn = lvl;
      prev_match = bus.alarm_match;
    end
  end

  function automatic logic [19:0] model_outs();
    logic ts, as, sh;
    logic [2:0] st;
    ts = (m_set == 1 || m_set == 2);
    as = (m_set == 3 || m_set == 4);
    sh = (m_set == 1 || m_set == 3);
    st = (m_alm == 1) ? 3'd5 : (m_alm == 2) ? 3'd6 : 3'(m_set);
    return {ts, as, sh, e_adv, ~ts, e_act, e_arst, m_alm == 1, st, 9'(m_left)};
  endfunction

  function automatic logic [19:0] outs();
    return {bus.time_set, bus.alarm_set, bus.sethrs1min0, bus.adv_pulse, bus.run,
            bus.activatealarm, bus.alarmreset, bus.buzzer, bus.state_o, bus.snooze_left};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (outs() !== 20'h08000) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", outs(), 20'h08000); end
    reset = 1'b0;
    step();
    n_cmp++; if (outs() !== 20'h08000) begin n_bad++; $display("FAIL reset_after: got %h expected %h", outs(), 20'h08000); end
  endtask

  task automatic test_set_mode();
    int advs;
    logic [6:0] exp_tab [4];
    exp_tab = '{{4'b1000, 3'd2}, {4'b0111, 3'd3}, {4'b0101, 3'd4}, {4'b0001, 3'd0}};
    bus.btn_mode = 1'b1;
    step();
    n_cmp++; if ({bus.time_set, bus.alarm_set, bus.sethrs1min0, bus.run, bus.state_o} !== {4'b1010, 3'd1}) begin
      n_bad++; $display("FAIL mode_enter: got %b expected %b", {bus.time_set, bus.alarm_set, bus.sethrs1min0, bus.run, bus.state_o}, {4'b1010, 3'd1}); end
    repeat (4) step();
    bus.btn_mode = 1'b0;
    step();
    n_cmp++; if (bus.state_o !== 3'd1) begin n_bad++; $display("FAIL mode_hold: got %0d expected 1", bus.state_o); end
    advs = 0;
    for (int p = 0; p < 3; p++) begin
      bus.btn_adv = 1'b1;
      for (int c = 0; c < 5; c++) begin step(); advs += int'(bus.adv_pulse); end
      bus.btn_adv = 1'b0;
      for (int c = 0; c < 2; c++) begin step(); advs += int'(bus.adv_pulse); end
    end
    n_cmp++; if (advs != 3) begin n_bad++; $display("FAIL adv_count: got %0d expected 3", advs); end
    for (int k = 0; k < 4; k++) begin
      bus.btn_mode = 1'b1;
      step();
      n_cmp++; if ({bus.time_set, bus.alarm_set, bus.sethrs1min0, bus.run, bus.state_o} !== exp_tab[k]) begin
        n_bad++; $display("FAIL mode_cycle%0d: got %b expected %b", k, {bus.time_set, bus.alarm_set, bus.sethrs1min0, bus.run, bus.state_o}, exp_tab[k]); end
      bus.btn_mode = 1'b0;
      step();
    end
    advs = 0;
    bus.btn_adv = 1'b1;
    step(); advs += int'(bus.adv_pulse);
    bus.btn_adv = 1'b0;
    step(); advs += int'(bus.adv_pulse);
    n_cmp++; if (advs != 0) begin n_bad++; $display("FAIL adv_in_run: got %0d expected 0", advs); end
  endtask

  task automatic test_ring_timeout();
    int arst;
    bus.alarm_en_sw = 1'b1;
    step();
    step();
    n_cmp++; if (bus.activatealarm !== 1'b1) begin n_bad++; $display("FAIL activatealarm: got %b expected 1", bus.activatealarm); end
    bus.alarm_match = 1'b1;
    step();
    n_cmp++; if ({bus.buzzer, bus.state_o} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL ring_start: got %b expected %b", {bus.buzzer, bus.state_o}, {1'b1, 3'd5}); end
    arst = 0;
    for (int i = 1; i <= RT; i++) begin
      bus.tick_1hz = 1'b1;
      step(); arst += int'(bus.alarmreset);
      bus.tick_1hz = 1'b0;
      step(); arst += int'(bus.alarmreset);
      if (i == RT - 1) begin
        n_cmp++; if ({bus.buzzer, bus.state_o} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL ring_before_timeout: got %b expected %b", {bus.buzzer, bus.state_o}, {1'b1, 3'd5}); end
      end
    end
    n_cmp++; if ({bus.buzzer, bus.state_o} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL ring_timeout_state: got %b expected %b", {bus.buzzer, bus.state_o}, {1'b0, 3'd0}); end
    n_cmp++; if (arst != 1) begin n_bad++; $display("FAIL ring_timeout_arst: got %0d expected 1", arst); end
    step();
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL match_no_retrigger: got %0d expected 0", bus.state_o); end
    bus.alarm_match = 1'b0;
    step();
  endtask

  task automatic test_snooze();
    bus.alarm_match = 1'b1;
    step();
    n_cmp++; if (bus.state_o !== 3'd5) begin n_bad++; $display("FAIL snz_ring: got %0d expected 5", bus.state_o); end
    for (int s = 0; s < MAXS; s++) begin
      bus.btn_snooze = 1'b1;
      step();
      n_cmp++; if ({bus.state_o, bus.buzzer, bus.snooze_left} !== {3'd6, 1'b0, 9'(SS)}) begin
        n_bad++; $display("FAIL snz_enter%0d: got %h expected %h", s, {bus.state_o, bus.buzzer, bus.snooze_left}, {3'd6, 1'b0, 9'(SS)}); end
      bus.btn_snooze = 1'b0;
      step();
      for (int k = 1; k <= SS; k++) begin
        tick_once();
        if (k < SS) begin
          n_cmp++; if ({bus.state_o, bus.snooze_left} !== {3'd6, 9'(SS - k)}) begin
            n_bad++; $display("FAIL snz_count%0d_%0d: got %h expected %h", s, k, {bus.state_o, bus.snooze_left}, {3'd6, 9'(SS - k)}); end
        end else begin
          n_cmp++; if ({bus.state_o, bus.buzzer, bus.snooze_left} !== {3'd5, 1'b1, 9'd0}) begin
            n_bad++; $display("FAIL snz_expire%0d: got %h expected %h", s, {bus.state_o, bus.buzzer, bus.snooze_left}, {3'd5, 1'b1, 9'd0}); end
        end
      end
    end
    bus.btn_snooze = 1'b1;
    step();
    n_cmp++; if ({bus.state_o, bus.buzzer, bus.snooze_left} !== {3'd5, 1'b1, 9'd0}) begin
      n_bad++; $display("FAIL snz_limit: got %h expected %h", {bus.state_o, bus.buzzer, bus.snooze_left}, {3'd5, 1'b1, 9'd0}); end
    bus.btn_snooze = 1'b0;
    step();
    n_cmp++; if (bus.buzzer !== 1'b1) begin n_bad++; $display("FAIL snz_limit_hold: got %b expected 1", bus.buzzer); end
  endtask

  task automatic test_stop_snooze();
    bus.btn_stop = 1'b1;
    bus.btn_snooze = 1'b1;
    step();
    n_cmp++; if ({bus.state_o, bus.alarmreset, bus.buzzer, bus.snooze_left} !== {3'd0, 1'b1, 1'b0, 9'd0}) begin
      n_bad++; $display("FAIL stop_snooze: got %h expected %h", {bus.state_o, bus.alarmreset, bus.buzzer, bus.snooze_left}, {3'd0, 1'b1, 1'b0, 9'd0}); end
    bus.btn_stop = 1'b0;
    bus.btn_snooze = 1'b0;
    step();
    n_cmp++; if ({bus.state_o, bus.alarmreset} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL stop_pulse_width: got %b expected %b", {bus.state_o, bus.alarmreset}, {3'd0, 1'b0}); end
    bus.alarm_match = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_snooze();
    bus.alarm_match = 1'b1;
    step();
    bus.btn_snooze = 1'b1;
    step();
    bus.btn_snooze = 1'b0;
    tick_once();
    n_cmp++; if ({bus.state_o, bus.snooze_left} !== {3'd6, 9'(SS - 1)}) begin
      n_bad++; $display("FAIL rst_snz_setup: got %h expected %h", {bus.state_o, bus.snooze_left}, {3'd6, 9'(SS - 1)}); end
    bus.alarm_match = 1'b0;
    reset = 1'b1;
    step();
    n_cmp++; if (outs() !== 20'h08000) begin n_bad++; $display("FAIL rst_snz_first: got %h expected %h", outs(), 20'h08000); end
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (outs() !== 20'h0C000) begin n_bad++; $display("FAIL rst_snz_after: got %h expected %h", outs(), 20'h0C000); end
  endtask

  task automatic test_random();
    bit [3:0] lvl;
    int rate [4] = '{8, 5, 10, 60};
    lvl = '0;
    bus.btn_mode = 0; bus.btn_adv = 0; bus.btn_snooze = 0; bus.btn_stop = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(rate[b] - 1) == 0) lvl[b] = ~lvl[b];
      {bus.btn_stop, bus.btn_snooze, bus.btn_adv, bus.btn_mode} = lvl;
      bus.tick_1hz = ($urandom_range(3) == 0);
      if ($urandom_range(149) == 0) bus.alarm_en_sw = ~bus.alarm_en_sw;
      if ($urandom_range(14) == 0) bus.alarm_match = ~bus.alarm_match;
      reset = ($urandom_range(399) == 0);
      step();
      n_cmp++; if (outs() !== model_outs()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h expected %h", c, outs(), model_outs()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_adv = 0; bus.btn_snooze = 0;
    bus.btn_stop = 0; bus.alarm_en_sw = 0; bus.alarm_match = 0;
    test_reset();
    test_set_mode();
    test_ring_timeout();
    test_snooze();
    test_stop_snooze();
    test_reset_mid_snooze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
